seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports are named Clock and Reset as elsewhere in the CPU.
REQ-002 Clock  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 A  in  32  dividend (register A value).
REQ-006 B  in  32  divisor (register B value).
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse; results valid.
REQ-009 div_zero  out  1  one-cycle pulse; divisor was zero (feeds exception control).
REQ-010 HI  out  32  remainder, registered, held until next successful division.
REQ-011 LO  out  32  quotient, registered, held until next successful division.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL, at rising edge k in IDLE with start=1 and B!=0, latch |A|, |B| and both operand signs, clear the iteration counter, and enter CALC.
REQ-014 SHALL perform one restoring shift/subtract iteration per cycle at edges k+1..k+32, then enter FIX at edge k+32.
REQ-015 SHALL, at edge k+33, write sign-corrected results to HI/LO and enter DONE; done=1 for exactly the following cycle.
REQ-016 SHALL return from DONE to IDLE at edge k+34; a start in that DONE cycle is ignored.
REQ-017 SHALL implement signed (MIPS div) semantics: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
REQ-018 SHALL produce LO=0x80000000, HI=0 for 0x80000000 / 0xFFFFFFFF, with no flag.
REQ-019 SHALL, at edge k in IDLE with start=1 and B==0, pulse div_zero for the following cycle only, leave HI/LO unchanged, and remain in IDLE.
REQ-020 SHALL ignore start while busy=1; latched operands SHALL NOT change until DONE.
REQ-021 SHALL never assert done and div_zero in the same cycle.
REQ-022 SHALL use only internal latched operands after edge k; A/B changes during CALC SHALL have no effect.

Reset
REQ-023 SHALL, on Reset=1 at any time including mid-CALC/FIX, immediately force IDLE, busy=0, done=0, div_zero=0, HI=0, LO=0, and clear the counter and internal registers.
REQ-024 SHALL accept a new start on the first rising edge after Reset deasserts.

Configuration
REQ-025 SHALL support macro SEQ_DIVIDER_DIVU_EN.
REQ-026 With SEQ_DIVIDER_DIVU_EN defined, SHALL add input port is_unsigned (1 bit, sampled with start); when 1, operands are treated as unsigned magnitudes and no sign correction is applied in FIX; timing is unchanged.
REQ-027 Without SEQ_DIVIDER_DIVU_EN, the is_unsigned port SHALL NOT exist and all divisions SHALL be signed.

Verification
REQ-028 A=100, B=7, start pulse -> busy high for 34 cycles, done at cycle 34 after start edge, LO=14, HI=2.
REQ-029 A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); A=7, B=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
REQ-030 A=5, B=0 -> div_zero pulses one cycle after start edge, busy stays 0, done stays 0, HI/LO keep prior values.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
REQ-032 Start division, assert Reset at cycle 10 of CALC -> all outputs 0 immediately; next start with A=9, B=3 -> LO=3, HI=0 with normal latency.
REQ-033 With SEQ_DIVIDER_DIVU_EN: A=0xFFFFFFFF, B=2, is_unsigned=1 -> LO=0x7FFFFFFF, HI=1; second start pulsed during CALC -> ignored, single done.

Source files
------------

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle 32-bit divider for the CPU's div instruction. A restoring
// shift/subtract datapath retires one quotient bit per clock. Divisions are
// signed: the quotient truncates toward zero and the remainder takes the sign
// of the dividend. A zero divisor is reported on div_zero and no division is
// started.
//
// Optional feature macro: SEQ_DIVIDER_DIVU_EN
//   When defined, an is_unsigned input is added. It is sampled together with
//   start; when it is 1 the operands are unsigned and no sign fix-up is
//   applied. Latency is the same in both modes.
//
// Ports
//   Clock       in   1  rising-edge clock
//   Reset       in   1  asynchronous, active-high reset
//   start       in   1  one-cycle request, only looked at in IDLE
//   A           in  32  dividend
//   B           in  32  divisor
//   is_unsigned in   1  (SEQ_DIVIDER_DIVU_EN only) unsigned division select
//   busy        out  1  high in CALC, FIX and DONE
//   done        out  1  one-cycle pulse, HI/LO hold the new result
//   div_zero    out  1  one-cycle pulse, request had a zero divisor
//   HI          out 32  remainder
//   LO          out 32  quotient
//
// Timing for a request accepted at edge k:
//   k        : operands latched, enter CALC
//   k+1..k+32: one iteration per edge, enter FIX at k+32
//   k+33     : HI/LO written, enter DONE (done high for that cycle)
//   k+34     : back to IDLE
// Handshake: start is a request that is honoured only while busy is low;
// there is no back-pressure, and a start seen while busy (including the
// DONE cycle) is dropped. Completion is signalled by exactly one done or
// div_zero pulse per accepted request, never both.
// ---------------------------------------------------------------------------
module seq_divider (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef SEQ_DIVIDER_DIVU_EN
    input  logic        is_unsigned,
`endif
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // State register is kept as a plain named signal so checkers can bind to it.
    state_t      state_q;
    logic [4:0]  cnt_q;       // iteration index 0..31
    logic [31:0] rem_q;       // partial remainder
    logic [31:0] quo_q;       // dividend shifting out / quotient shifting in
    logic [31:0] dvs_q;       // divisor magnitude
    logic        sign_a_q;    // dividend was negative (signed mode only)
    logic        sign_b_q;    // divisor was negative (signed mode only)
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Mode select; the default build is always signed.
    logic uns_w;
`ifdef SEQ_DIVIDER_DIVU_EN
    assign uns_w = is_unsigned;
`else
    assign uns_w = 1'b0;
`endif

    // Operand signs and magnitudes as seen at the request edge. The negation
    // of 0x80000000 is 0x80000000, which is the correct unsigned magnitude.
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] a_mag_d;
    logic [31:0] b_mag_d;

    assign a_neg_d = A[31] & ~uns_w;
    assign b_neg_d = B[31] & ~uns_w;
    assign a_mag_d = a_neg_d ? (32'd0 - A) : A;
    assign b_mag_d = b_neg_d ? (32'd0 - B) : B;

    // One restoring step. The shifted remainder needs 33 bits because the
    // divisor may be as large as 0xFFFFFFFF in unsigned mode; when the trial
    // subtraction succeeds its result is below the divisor, so 32 bits hold it.
    logic [32:0] rem_shift_d;
    logic        fits_d;
    logic [31:0] sub_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    assign rem_shift_d = {rem_q, quo_q[31]};
    assign fits_d      = (rem_shift_d >= {1'b0, dvs_q});
    assign sub_d       = rem_shift_d[31:0] - dvs_q;
    assign rem_d       = fits_d ? sub_d : rem_shift_d[31:0];
    assign quo_d       = {quo_q[30:0], fits_d};

    // Sign fix-up applied in FIX: quotient is negative when the operand signs
    // differ, remainder follows the dividend.
    logic [31:0] lo_fix_d;
    logic [31:0] hi_fix_d;

    assign lo_fix_d = (sign_a_q ^ sign_b_q) ? (32'd0 - quo_q) : quo_q;
    assign hi_fix_d = sign_a_q ? (32'd0 - rem_q) : rem_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            // Both flags are single-cycle pulses.
            done_q <= 1'b0;
            dz_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (B == 32'd0) begin
                            dz_q <= 1'b1;
                        end else begin
                            quo_q    <= a_mag_d;
                            dvs_q    <= b_mag_d;
                            sign_a_q <= a_neg_d;
                            sign_b_q <= b_neg_d;
                            rem_q    <= 32'd0;
                            cnt_q    <= 5'd0;
                            busy_q   <= 1'b1;
                            state_q  <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end
                end

                S_FIX: begin
                    lo_q    <= lo_fix_d;
                    hi_q    <= hi_fix_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule
